stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stack_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl -- call/return sequencer for an external return-address stack.
//
// A call in IDLE pushes the return address (pc+1) and loads the target into
// the fetch unit one cycle later. A return pops the stack, waits one cycle
// for the stack read data, then loads it into the fetch unit (3 cycles from
// request to pc_load). Overflow or underflow latches a sticky error flag
// and parks the FSM in ERR until reset.
//
// Optional feature macro: STACK_CTRL_IRQ_EN
//   Adds irq/irq_vec. An interrupt in IDLE outranks call and ret and runs
//   the call sequence, pushing pc itself (not pc+1) and jumping to irq_vec.
//
// Handshake: call/ret (and irq) are level requests sampled only while busy=0.
//   A request seen while busy=1 is dropped, not queued; the requester must
//   hold or re-assert it. stk_push/stk_pop/pc_load are one-cycle strobes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   call, pc, target  call request, current PC, call destination
//   ret             return request
//   irq, irq_vec    interrupt request and vector (STACK_CTRL_IRQ_EN only)
//   stk_push, stk_pop, stk_addr_in   return-stack controls and push data
//   stk_addr_out    return-stack pop data, valid the cycle after stk_pop
//   next_pc, pc_load  fetch-unit load address and strobe
//   busy, full, empty, depth          status
//   ovf_err, unf_err                  sticky error flags
//   dbg_state       current FSM state encoding
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int AW    = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     call,
  input  logic [AW-1:0]            pc,
  input  logic [AW-1:0]            target,
  input  logic                     ret,
`ifdef STACK_CTRL_IRQ_EN
  input  logic                     irq,
  input  logic [AW-1:0]            irq_vec,
`endif
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [AW-1:0]            stk_addr_in,
  input  logic [AW-1:0]            stk_addr_out,
  output logic [AW-1:0]            next_pc,
  output logic                     pc_load,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     ovf_err,
  output logic                     unf_err,
  output logic [2:0]               dbg_state
);

  localparam int DW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALL  = 3'd1,
    S_POP   = 3'd2,
    S_RLOAD = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_depth;
  logic [AW-1:0]   r_next_pc;
  logic [AW-1:0]   r_addr_in;
  logic            r_push;
  logic            r_pop;
  logic            r_pc_load;
  logic            r_ovf;
  logic            r_unf;

  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_pc_inc;
  logic            w_take_call;
  logic [AW-1:0]   w_push_addr;
  logic [AW-1:0]   w_dest;

  assign w_full   = (r_depth == DW'(DEPTH));
  assign w_empty  = (r_depth == '0);
  // Wraps naturally at 2^AW, so the all-ones PC returns to address 0.
  assign w_pc_inc = pc + {{(AW-1){1'b0}}, 1'b1};

  // Anything that runs the push sequence, plus what it pushes and where it jumps.
`ifdef STACK_CTRL_IRQ_EN
  assign w_take_call = irq | call;
  assign w_push_addr = irq ? pc : w_pc_inc;
  assign w_dest      = irq ? irq_vec : target;
`else
  assign w_take_call = call;
  assign w_push_addr = w_pc_inc;
  assign w_dest      = target;
`endif

  // Strobes are registered on the edge that enters CALL/POP/IDLE-from-RLOAD,
  // so they are visible for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_depth   <= '0;
      r_next_pc <= '0;
      r_addr_in <= '0;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_pc_load <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_pc_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Call outranks ret; a simultaneous ret is dropped.
          if (w_take_call) begin
            if (w_full) begin
              r_ovf   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_push    <= 1'b1;
              r_addr_in <= w_push_addr;
              r_next_pc <= w_dest;
              r_pc_load <= 1'b1;
              r_depth   <= r_depth + 1'b1;
              r_state   <= S_CALL;
            end
          end else if (ret) begin
            if (w_empty) begin
              r_unf   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_pop   <= 1'b1;
              r_depth <= r_depth - 1'b1;
              r_state <= S_POP;
            end
          end
        end
        S_CALL:  r_state <= S_IDLE;
        // Stack read data lands during RLOAD, one cycle after the pop strobe.
        S_POP:   r_state <= S_RLOAD;
        S_RLOAD: begin
          r_next_pc <= stk_addr_out;
          r_pc_load <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stk_push    = r_push;
  assign stk_pop     = r_pop;
  assign stk_addr_in = r_addr_in;
  assign next_pc     = r_next_pc;
  assign pc_load     = r_pc_load;
  assign busy        = (r_state != S_IDLE);
  assign full        = w_full;
  assign empty       = w_empty;
  assign depth       = r_depth;
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl -- directed bench for stack_ctrl (AW=12, DEPTH=8).
// A behavioural return stack answers stk_push/stk_pop; expected return
// addresses are hand-computed and held in exp_q.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam logic [2:0] ST_ERR = 3'd4;

  logic          clk;
  logic          rst;
  logic          call;
  logic [AW-1:0] pc;
  logic [AW-1:0] target;
  logic          ret;
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_addr_in;
  logic [AW-1:0] stk_addr_out = '0;
  logic [AW-1:0] next_pc;
  logic          pc_load;
  logic          busy;
  logic          full;
  logic          empty;
  logic [3:0]    depth;
  logic          ovf_err;
  logic          unf_err;
  logic [2:0]    dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] stk_mem[$];

  stack_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .call         (call),
    .pc           (pc),
    .target       (target),
    .ret          (ret),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_addr_in  (stk_addr_in),
    .stk_addr_out (stk_addr_out),
    .next_pc      (next_pc),
    .pc_load      (pc_load),
    .busy         (busy),
    .full         (full),
    .empty        (empty),
    .depth        (depth),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural return stack: pop data valid the cycle after stk_pop.
  always @(posedge clk) begin
    if (rst) begin
      stk_mem.delete();
    end else begin
      if (stk_push) stk_mem.push_back(stk_addr_in);
      if (stk_pop && stk_mem.size() > 0) stk_addr_out <= stk_mem.pop_back();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_depth"},   32'(depth),       32'd0);
    chk({tag, "_empty"},   32'(empty),       32'd1);
    chk({tag, "_full"},    32'(full),        32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_pcload"},  32'(pc_load),     32'd0);
    chk({tag, "_nextpc"},  32'(next_pc),     32'd0);
    chk({tag, "_addrin"},  32'(stk_addr_in), 32'd0);
    chk({tag, "_push"},    32'(stk_push),    32'd0);
    chk({tag, "_pop"},     32'(stk_pop),     32'd0);
    chk({tag, "_ovf"},     32'(ovf_err),     32'd0);
    chk({tag, "_unf"},     32'(unf_err),     32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_ret;
    rst = 1'b1; call = 1'b0; ret = 1'b0; pc = '0; target = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Call pc=03F -> push 040, jump to 100
    call = 1'b1; pc = 12'h03F; target = 12'h100;
    exp_q.push_back(12'h040);
    tick();
    call = 1'b0;
    chk("c1_push",   32'(stk_push),    32'd1);
    chk("c1_addrin", 32'(stk_addr_in), 32'h040);
    chk("c1_pcload", 32'(pc_load),     32'd1);
    chk("c1_nextpc", 32'(next_pc),     32'h100);
    chk("c1_depth",  32'(depth),       32'd1);
    chk("c1_busy",   32'(busy),        32'd1);
    tick();
    chk("c1_push_off",   32'(stk_push), 32'd0);
    chk("c1_pcload_off", 32'(pc_load),  32'd0);
    chk("c1_idle",       32'(busy),     32'd0);

    // Call pc=1FF -> push 200
    call = 1'b1; pc = 12'h1FF; target = 12'h300;
    exp_q.push_back(12'h200);
    tick();
    call = 1'b0;
    chk("c2_addrin", 32'(stk_addr_in), 32'h200);
    chk("c2_nextpc", 32'(next_pc),     32'h300);
    chk("c2_depth",  32'(depth),       32'd2);
    tick();

    // First ret -> 200 after 3 cycles
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("r1_pop",    32'(stk_pop), 32'd1);
    chk("r1_push",   32'(stk_push), 32'd0);
    chk("r1_depth",  32'(depth),   32'd1);
    chk("r1_busy",   32'(busy),    32'd1);
    chk("r1_pcl_c1", 32'(pc_load), 32'd0);
    tick();
    chk("r1_pop_off", 32'(stk_pop), 32'd0);
    chk("r1_pcl_c2",  32'(pc_load), 32'd0);
    tick();
    exp_ret = exp_q.pop_back();
    chk("r1_pcload", 32'(pc_load), 32'd1);
    chk("r1_nextpc", 32'(next_pc), 32'(exp_ret));
    chk("r1_notbusy", 32'(busy),   32'd0);
    tick();
    chk("r1_pcl_off", 32'(pc_load), 32'd0);

    // Second ret -> 040; a call during POP must be ignored
    ret = 1'b1;
    tick();
    ret = 1'b0;
    call = 1'b1; pc = 12'h555; target = 12'h666;
    tick();
    call = 1'b0;
    chk("r2_busy_call_push", 32'(stk_push), 32'd0);
    chk("r2_busy_call_dep",  32'(depth),    32'd0);
    tick();
    exp_ret = exp_q.pop_back();
    chk("r2_pcload", 32'(pc_load), 32'd1);
    chk("r2_nextpc", 32'(next_pc), 32'(exp_ret));
    chk("r2_depth",  32'(depth),   32'd0);
    chk("r2_empty",  32'(empty),   32'd1);
    tick();
    chk("r2_no_late_push", 32'(stk_push), 32'd0);

    // call and ret together with depth 0 -> push only
    call = 1'b1; ret = 1'b1; pc = 12'h010; target = 12'h020;
    tick();
    call = 1'b0; ret = 1'b0;
    chk("cr_push",   32'(stk_push),    32'd1);
    chk("cr_pop",    32'(stk_pop),     32'd0);
    chk("cr_addrin", 32'(stk_addr_in), 32'h011);
    chk("cr_depth",  32'(depth),       32'd1);
    chk("cr_unf",    32'(unf_err),     32'd0);
    tick();
    chk("cr_pop_later", 32'(stk_pop), 32'd0);
    do_reset();

    // DEPTH calls fill the stack, the next overflows
    for (int i = 0; i < DEPTH; i++) begin
      call = 1'b1; pc = 12'(i * 16); target = 12'h400;
      tick();
      call = 1'b0;
      chk("fill_push", 32'(stk_push), 32'd1);
      tick();
    end
    chk("fill_depth", 32'(depth), 32'd8);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    call = 1'b1; pc = 12'h0F0; target = 12'h400;
    tick();
    call = 1'b0;
    chk("ovf_push",  32'(stk_push),  32'd0);
    chk("ovf_flag",  32'(ovf_err),   32'd1);
    chk("ovf_state", 32'(dbg_state), 32'(ST_ERR));
    chk("ovf_busy",  32'(busy),      32'd1);
    chk("ovf_pcl",   32'(pc_load),   32'd0);
    chk("ovf_depth", 32'(depth),     32'd8);
    ret = 1'b1;
    tick();
    tick();
    ret = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_hold",   32'(busy),    32'd1);
    chk("ovf_nopop",  32'(stk_pop), 32'd0);
    chk("ovf_depth2", 32'(depth),   32'd8);
    do_reset();
    chk_reset_state("ovf_rst");

    // ret when empty -> underflow, sticky for 10 cycles
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("unf_flag",  32'(unf_err),   32'd1);
    chk("unf_pop",   32'(stk_pop),   32'd0);
    chk("unf_pcl",   32'(pc_load),   32'd0);
    chk("unf_state", 32'(dbg_state), 32'(ST_ERR));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("unf_hold_flag", 32'(unf_err), 32'd1);
      chk("unf_hold_pop",  32'(stk_pop), 32'd0);
      chk("unf_hold_pcl",  32'(pc_load), 32'd0);
    end
    chk("unf_no_ovf", 32'(ovf_err), 32'd0);
    do_reset();
    chk_reset_state("unf_rst");

    // Call from 0xFFF wraps the return address to 0x000
    call = 1'b1; pc = 12'hFFF; target = 12'hABC;
    tick();
    call = 1'b0;
    chk("wrap_addrin", 32'(stk_addr_in), 32'h000);
    chk("wrap_nextpc", 32'(next_pc),     32'hABC);
    tick();

    // Reset while in POP: no pc_load follows, depth returns to 0
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("rp_pop", 32'(stk_pop), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("rp_rst");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rp_no_pcl", 32'(pc_load), 32'd0);
    end
    chk("rp_depth", 32'(depth), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
